// File: rtl/arcade_pkg.sv
// arcade_pkg: types and defaults shared by the arcade sprite/collision blocks.
//   coll_state_t          ship collision FSM state (ARMED / GRACE)
//   DEFAULT_GRACE_FRAMES  frames of ship invulnerability after a hit or reset
//   DEFAULT_N_AST         number of asteroid sprite units
//   DEFAULT_N_SHOT        number of shot sprite units
package arcade_pkg;

  typedef enum logic {ARMED, GRACE} coll_state_t;

  localparam int DEFAULT_GRACE_FRAMES = 120;
  localparam int DEFAULT_N_AST        = 8;
  localparam int DEFAULT_N_SHOT       = 4;

endpackage

// File: rtl/sticky_flags.sv
// sticky_flags: W-bit set-only flag register with a frame-boundary snapshot.
//   clk, resetN  clock, asynchronous active-low reset
//   set   [W]    bits to OR into the flags
//   en           qualifies set (pixel inside the visible area)
//   clear        frame boundary: snapshot the flags and restart accumulation
//   flags [W]    running accumulation for the current frame
//   snap  [W]    one-cycle copy of flags, valid the clock after clear
module sticky_flags #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic [W-1:0] set,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] flags,
  output logic [W-1:0] snap
);

  logic [W-1:0] set_gated;

  assign set_gated = en ? set : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flags <= '0;
      snap  <= '0;
    end else begin
      // snap is a pulse: it carries the finished frame for exactly one cycle.
      snap  <= clear ? flags : '0;
      // The overlap seen on the clear cycle itself starts the new frame.
      flags <= (clear ? '0 : flags) | set_gated;
    end
  end

endmodule

// File: rtl/collision_unit.sv
// collision_unit: per-frame ship/asteroid/shot collision detector.
//   clk, resetN   clock, asynchronous active-low reset
//   frame_start   one-cycle pulse on the first clock of each frame
//   active        pixel is inside the visible area
//   draw_ship     ship sprite drawing at this pixel
//   draw_ast      per-asteroid draw strobes [N_AST]
//   draw_shot     per-shot draw strobes [N_SHOT]
//   ship_hit      pulse: ship hit an asteroid last frame (suppressed in grace)
//   ast_hit       pulse vector: asteroid hit by a shot or the ship
//   shot_hit      pulse vector: shot hit an asteroid
//   frame_valid   pulse qualifying the hit outputs (clock after frame_start)
//   grace         level: ship invulnerable
//   hit_count     saturating count of asteroids hit by shots
// GRACE_FRAMES must be at least 1.
module collision_unit #(
  parameter int N_AST        = arcade_pkg::DEFAULT_N_AST,
  parameter int N_SHOT       = arcade_pkg::DEFAULT_N_SHOT,
  parameter int GRACE_FRAMES = arcade_pkg::DEFAULT_GRACE_FRAMES,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              frame_start,
  input  logic              active,
  input  logic              draw_ship,
  input  logic [N_AST-1:0]  draw_ast,
  input  logic [N_SHOT-1:0] draw_shot,
  output logic              ship_hit,
  output logic [N_AST-1:0]  ast_hit,
  output logic [N_SHOT-1:0] shot_hit,
  output logic              frame_valid,
  output logic              grace,
  output logic [CNT_W-1:0]  hit_count
);

  import arcade_pkg::*;

  localparam int GW = $clog2(GRACE_FRAMES + 1);
  localparam int PW = $clog2(N_AST + 1);
  localparam int SW = CNT_W + PW;
  localparam logic [GW-1:0]    GRACE_INIT = GW'(GRACE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic              any_ast;
  logic              any_shot;
  logic              ship_set;
  logic [2*N_AST-1:0] ast_set;
  logic [N_SHOT-1:0] shot_set;

  logic              ship_flags;
  logic              ship_snap;
  logic [2*N_AST-1:0] ast_flags;
  logic [2*N_AST-1:0] ast_snap;
  logic [N_SHOT-1:0] shot_flags;
  logic              unused_flags;

  coll_state_t       state;
  logic [GW-1:0]     grace_cnt;
  logic              armed_at_publish;
  logic [PW-1:0]     shot_pop;
  logic [SW-1:0]     count_sum;
  logic [CNT_W-1:0]  count_next;

  assign any_ast  = |draw_ast;
  assign any_shot = |draw_shot;
  assign ship_set = draw_ship & any_ast;
  // Asteroid flags are split by cause: low half shot-caused (scored),
  // high half ship-caused (reported but not scored).
  assign ast_set  = {draw_ast & {N_AST{draw_ship}}, draw_ast & {N_AST{any_shot}}};
  assign shot_set = draw_shot & {N_SHOT{any_ast}};

  sticky_flags #(.W(1)) u_ship (
    .clk(clk), .resetN(resetN), .set(ship_set), .en(active),
    .clear(frame_start), .flags(ship_flags), .snap(ship_snap)
  );

  sticky_flags #(.W(2*N_AST)) u_ast (
    .clk(clk), .resetN(resetN), .set(ast_set), .en(active),
    .clear(frame_start), .flags(ast_flags), .snap(ast_snap)
  );

  sticky_flags #(.W(N_SHOT)) u_shot (
    .clk(clk), .resetN(resetN), .set(shot_set), .en(active),
    .clear(frame_start), .flags(shot_flags), .snap(shot_hit)
  );

  // Only the shot-caused asteroid accumulator feeds logic directly.
  assign unused_flags = ^{shot_flags, ast_flags[2*N_AST-1:N_AST]};

  assign ast_hit  = ast_snap[N_AST-1:0] | ast_snap[2*N_AST-1:N_AST];
  assign ship_hit = ship_snap & armed_at_publish;
  assign grace    = (state == GRACE);

  // Popcount over asteroids, so two shots on one asteroid score once.
  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    shot_pop = '0;
    for (int a = 0; a < N_AST; a++) begin
      shot_pop = shot_pop + PW'(ast_flags[a]);
    end
  end

  assign count_sum  = SW'(hit_count) + SW'(shot_pop);
  assign count_next = (count_sum > SW'(CNT_MAX)) ? CNT_MAX : count_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= GRACE;
      grace_cnt        <= GRACE_INIT;
      armed_at_publish <= 1'b0;
      frame_valid      <= 1'b0;
      hit_count        <= '0;
    end else begin
      frame_valid      <= frame_start;
      // Captures the pre-publish state, so a hit that re-enters GRACE still pulses.
      armed_at_publish <= frame_start && (state == ARMED);
      if (frame_start) begin
        hit_count <= count_next;
        case (state)
          ARMED: begin
            if (ship_flags) begin
              state     <= GRACE;
              grace_cnt <= GRACE_INIT;
            end
          end
          GRACE: begin
            if (grace_cnt == GW'(1)) begin
              state     <= ARMED;
              grace_cnt <= '0;
            end else begin
              grace_cnt <= grace_cnt - GW'(1);
            end
          end
          default: state <= GRACE;
        endcase
      end
    end
  end

endmodule
